// File: rtl/frame_serializer_if.sv
// Byte-in / bit-out handshake bundle for frame_serializer.
// The master modport belongs to the byte producer; the slave modport belongs to the serializer.
interface frame_serializer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       data;
  logic       frame;
  logic       busy;

  modport master (output tx_data, output tx_valid,
                  input tx_ready, input data, input frame, input busy);
  modport slave  (input tx_data, input tx_valid,
                  output tx_ready, output data, output frame, output busy);
endinterface

// File: rtl/frame_serializer.sv
// Byte-to-serial framer: MSB first, whole bytes only, fixed GAP after each frame.
// Optional per-frame bit-pair counters are compiled in with FRAME_SERIALIZER_PAIRCNT_EN.
module frame_serializer #(
  parameter int MAX_WORDS  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  frame_serializer_if.slave bus
`ifdef FRAME_SERIALIZER_PAIRCNT_EN
  ,
  output logic [7:0] cnt00,
  output logic [7:0] cnt01,
  output logic [7:0] cnt10,
  output logic [7:0] cnt11
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;

  localparam logic [7:0] MAX_W    = 8'(MAX_WORDS);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state_r, state_s;
  logic [7:0] shreg_r, shreg_s;
  logic [2:0] bit_r,   bit_s;
  logic [7:0] wcnt_r,  wcnt_s;
  logic [3:0] gap_r,   gap_s;
  logic       data_r,  data_s;
  logic       frame_r, frame_s;
  logic       busy_r,  busy_s;
  logic       ready_r, ready_s;
  logic       accept_s;

  // Next-state: accept only while the registered tx_ready is high.
  always_comb begin
    state_s  = state_r;
    shreg_s  = shreg_r;
    bit_s    = bit_r;
    wcnt_s   = wcnt_r;
    gap_s    = gap_r;
    accept_s = bus.tx_valid & ready_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = SHIFT;
          shreg_s = bus.tx_data;
          bit_s   = 3'd7;
          wcnt_s  = 8'd1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (bit_r != 3'd0) begin
          bit_s = bit_r - 3'd1;
        end else if (accept_s) begin
          shreg_s = bus.tx_data;
          bit_s   = 3'd7;
          wcnt_s  = wcnt_r + 8'd1;
        end else begin
          state_s = GAP;
          gap_s   = GAP_LAST;
        end
      end
      GAP: begin
        if (gap_r == 4'd0) begin
          state_s = IDLE;
        end else begin
          gap_s = gap_r - 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode of the next state so every output leaves a flop.
  always_comb begin
    data_s  = 1'b0;
    frame_s = 1'b0;
    ready_s = 1'b0;
    busy_s  = (state_s != IDLE);
    case (state_s)
      IDLE: begin
        ready_s = 1'b1;
      end
      SHIFT: begin
        frame_s = 1'b1;
        data_s  = shreg_s[bit_s];
        ready_s = (bit_s == 3'd0) && (wcnt_s < MAX_W);
      end
      GAP: begin
        ready_s = 1'b0;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides any accept on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      shreg_r <= 8'h00;
      bit_r   <= 3'd0;
      wcnt_r  <= 8'd0;
      gap_r   <= 4'd0;
      data_r  <= 1'b0;
      frame_r <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      bit_r   <= bit_s;
      wcnt_r  <= wcnt_s;
      gap_r   <= gap_s;
      data_r  <= data_s;
      frame_r <= frame_s;
      busy_r  <= busy_s;
      ready_r <= ready_s;
    end
  end

  assign bus.data     = data_r;
  assign bus.frame    = frame_r;
  assign bus.busy     = busy_r;
  assign bus.tx_ready = ready_r;

`ifdef FRAME_SERIALIZER_PAIRCNT_EN
  logic [7:0] cnt_r [4];
  logic [1:0] pair_s;

  // Pair value (first bit as MSB); meaningful only when bit_s is even.
  always_comb begin
    pair_s = {shreg_s[bit_s + 3'd1], shreg_s[bit_s]};
  end

  // Counters clear as a frame starts and bump when a pair's second bit goes out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_r[i] <= 8'h00;
    end else if ((state_r == IDLE) && (state_s == SHIFT)) begin
      for (int i = 0; i < 4; i++) cnt_r[i] <= 8'h00;
    end else if ((state_s == SHIFT) && !bit_s[0]) begin
      cnt_r[pair_s] <= cnt_r[pair_s] + 8'd1;
    end else begin
      for (int i = 0; i < 4; i++) cnt_r[i] <= cnt_r[i];
    end
  end

  assign cnt00 = cnt_r[0];
  assign cnt01 = cnt_r[1];
  assign cnt10 = cnt_r[2];
  assign cnt11 = cnt_r[3];
`endif

endmodule
